// File: rtl/dma_pkg.sv
// Shared constants, FSM state and transfer-direction types for the DMA channel engine.
package dma_pkg;

  localparam logic [15:0] REG_BASE  = 16'd0;
  localparam logic [15:0] REG_COUNT = 16'd1;
  localparam logic [15:0] REG_CMD   = 16'd7;
  localparam logic [15:0] REG_MODE  = 16'd10;
  localparam logic [15:0] REG_MASK  = 16'd11;
  localparam logic [15:0] REG_REQ   = 16'd12;
  localparam logic [15:0] REG_DST   = 16'd13;

  // Mode register bits [3:2]
  localparam logic [1:0] MODE_IO2MEM = 2'b10;
  localparam logic [1:0] MODE_MEM2IO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_M2M,
    DIR_IO2M,
    DIR_M2IO
  } dir_e;

  // mem->mem enable takes priority over the mode field
  function automatic dir_e dir_decode(input logic m2m_en, input logic [1:0] xfer_mode);
    dir_e d;
    d = DIR_NONE;
    if (m2m_en)                          d = DIR_M2M;
    else if (xfer_mode == MODE_IO2MEM)   d = DIR_IO2M;
    else if (xfer_mode == MODE_MEM2IO)   d = DIR_M2IO;
    return d;
  endfunction

endpackage

// File: rtl/dma_reg_file.sv
// Programmed channel registers with address decode and busy write-gating.
// DMA_AUTOINIT_EN: stores mode bit4 and reports it as the auto-init enable.
module dma_reg_file
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [15:0]       addr_i,
  input  logic [15:0]       wdata_i,
  input  logic              busy_i,
  input  logic              set_mask_i,
  output logic [ADDR_W-1:0] base_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [15:0]       count_o,
  output dir_e              dir_o,
  output logic              autoinit_o,
  output logic              mask_o,
  output logic              req_o,
  output logic              abort_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [15:0]       count_q, count_d;
  logic              cmd_q, cmd_d;
  logic [1:0]        mode_q, mode_d;
  logic              mask_q, mask_d;
`ifdef DMA_AUTOINIT_EN
  logic              auto_q, auto_d;
`endif

  always_comb begin
    base_d  = base_q;
    dst_d   = dst_q;
    count_d = count_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
`ifdef DMA_AUTOINIT_EN
    auto_d  = auto_q;
`endif
    if (we_i && !busy_i) begin
      case (addr_i)
        REG_BASE:  base_d  = ADDR_W'(wdata_i);
        REG_COUNT: count_d = wdata_i;
        REG_CMD:   cmd_d   = wdata_i[0];
        REG_MODE: begin
          mode_d = wdata_i[3:2];
`ifdef DMA_AUTOINIT_EN
          auto_d = wdata_i[4];
`endif
        end
        REG_DST:   dst_d   = ADDR_W'(wdata_i);
        default: ;
      endcase
    end
    // Mask stays writable during a transfer; completion setting it has the last word
    if (we_i && addr_i == REG_MASK) mask_d = wdata_i[0];
    if (set_mask_i)                 mask_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q  <= '0;
      dst_q   <= '0;
      count_q <= '0;
      cmd_q   <= 1'b0;
      mode_q  <= '0;
      mask_q  <= 1'b1;
`ifdef DMA_AUTOINIT_EN
      auto_q  <= 1'b0;
`endif
    end else begin
      base_q  <= base_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
`ifdef DMA_AUTOINIT_EN
      auto_q  <= auto_d;
`endif
    end
  end

`ifdef DMA_AUTOINIT_EN
  assign autoinit_o = auto_q;
`else
  assign autoinit_o = 1'b0;
`endif

  assign base_o  = base_q;
  assign dst_o   = dst_q;
  assign count_o = count_q;
  assign mask_o  = mask_q;
  assign dir_o   = dir_decode(cmd_q, mode_q);
  assign req_o   = we_i && (addr_i == REG_REQ);
  assign abort_o = we_i && (addr_i == REG_MASK) && wdata_i[0];

endmodule

// File: rtl/dma_channel_engine.sv
// Single DMA channel: register slave plus word-transfer FSM (mem->mem, IO->mem, mem->IO).
// DMA_AUTOINIT_EN: completion reloads the working registers and leaves the channel unmasked.
module dma_channel_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic [15:0]       reg_addr,
  input  logic [15:0]       reg_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              io_req,
  output logic              io_we,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,
  output logic              busy,
  output logic              tc
);

  typedef struct packed {
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              io_req;
    logic              io_we;
    logic [DATA_W-1:0] io_wdata;
  } bus_t;

  function automatic bus_t rd_bus(input dir_e d, input logic [ADDR_W-1:0] a);
    bus_t b;
    b = '0;
    if (d == DIR_IO2M) begin
      b.io_req = 1'b1;
    end else begin
      b.mem_req  = 1'b1;
      b.mem_addr = a;
    end
    return b;
  endfunction

  function automatic bus_t wr_bus(input dir_e d, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] data);
    bus_t b;
    b = '0;
    if (d == DIR_M2IO) begin
      b.io_req   = 1'b1;
      b.io_we    = 1'b1;
      b.io_wdata = data;
    end else begin
      b.mem_req   = 1'b1;
      b.mem_we    = 1'b1;
      b.mem_addr  = a;
      b.mem_wdata = data;
    end
    return b;
  endfunction

  state_e            state_q;
  dir_e              dir_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [15:0]       cnt_q;
  bus_t              bus_q;
  logic              busy_q, tc_q;

  logic [ADDR_W-1:0] prog_base, prog_dst;
  logic [15:0]       prog_count;
  dir_e              prog_dir;
  logic              autoinit, mask, req_wr, abort;

  dma_reg_file #(
    .ADDR_W(ADDR_W)
  ) u_regs (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (reg_we),
    .addr_i    (reg_addr),
    .wdata_i   (reg_wdata),
    .busy_i    (busy_q),
    .set_mask_i((state_q == ST_DONE) && !autoinit),
    .base_o    (prog_base),
    .dst_o     (prog_dst),
    .count_o   (prog_count),
    .dir_o     (prog_dir),
    .autoinit_o(autoinit),
    .mask_o    (mask),
    .req_o     (req_wr),
    .abort_o   (abort)
  );

  logic              start, rd_ack, wr_ack;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] src_next, dst_next, start_dst;

  assign start     = (state_q == ST_IDLE) && req_wr && !mask && (prog_dir != DIR_NONE);
  assign rd_ack    = (dir_q == DIR_IO2M) ? io_ack : mem_ack;
  assign wr_ack    = (dir_q == DIR_M2IO) ? io_ack : mem_ack;
  assign rd_data   = (dir_q == DIR_IO2M) ? io_rdata : mem_rdata;
  assign src_next  = src_q + ADDR_W'(STRIDE);
  assign dst_next  = dst_q + ADDR_W'(STRIDE);
  // Only mem->mem uses the separate destination register; otherwise reg0 is the memory side
  assign start_dst = (prog_dir == DIR_M2M) ? prog_dst : prog_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (prog_count == 16'd0) begin
              state_q <= ST_DONE;
              tc_q    <= 1'b1;
            end else begin
              dir_q   <= prog_dir;
              src_q   <= prog_base;
              dst_q   <= start_dst;
              cnt_q   <= prog_count;
              busy_q  <= 1'b1;
              bus_q   <= rd_bus(prog_dir, prog_base);
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            bus_q   <= '0;
          end else if (rd_ack) begin
            bus_q   <= wr_bus(dir_q, dst_q, rd_data);
            state_q <= ST_WR;
          end
        end
        ST_WR: begin
          // Abort beats a coincident write ack: the word is not counted
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            bus_q   <= '0;
          end else if (wr_ack) begin
            cnt_q <= cnt_q - 16'd1;
            src_q <= src_next;
            dst_q <= dst_next;
            if (cnt_q == 16'd1) begin
              state_q <= ST_DONE;
              tc_q    <= 1'b1;
              busy_q  <= 1'b0;
              bus_q   <= '0;
            end else begin
              bus_q   <= rd_bus(dir_q, src_next);
              state_q <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (autoinit) begin
            src_q <= prog_base;
            dst_q <= start_dst;
            cnt_q <= prog_count;
          end
        end
      endcase
    end
  end

  assign mem_req   = bus_q.mem_req;
  assign mem_we    = bus_q.mem_we;
  assign mem_addr  = bus_q.mem_addr;
  assign mem_wdata = bus_q.mem_wdata;
  assign io_req    = bus_q.io_req;
  assign io_we     = bus_q.io_we;
  assign io_wdata  = bus_q.io_wdata;
  assign busy      = busy_q;
  assign tc        = tc_q;

endmodule
